nibble_serial_adder_ctrl: RTL
=============================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//  Sequencer that reuses one 4-bit ripple-carry add slice to add or subtract two
//  multi-nibble two's-complement operands, one nibble per clock, LSB nibble first.
//  Carry is chained between nibbles through a register, so a 16-bit add costs 4
//  cycles of one 4-bit adder. Sits between a requesting unit (start/done) and the
//  4-bit adder datapath. Reports sum, carryout and overflow with 4-bit adder semantics.
// PARAMETERS
//  WORDS   4   number of 4-bit nibbles per operand; operand width W = 4*WORDS (WORDS>=1)
// PORTS
//  clk       in   1    clock; all state changes on rising edge
//  reset     in   1    asynchronous, active-high; clears all state and outputs
//  start     in   1    request; sampled only when ready=1
//  sub       in   1    0: a+b ; 1: a-b (b inverted, carry-in 1); sampled with start
//  a         in   W    operand A, two's complement; sampled with start
//  b         in   W    operand B, two's complement; sampled with start
//  ready     out  1    1 in IDLE and DONE states (start accepted)
//  busy      out  1    1 in RUN state only
//  done      out  1    one-cycle pulse; sum/carryout/overflow valid from this cycle
//  sum       out  W    result, held until next completion
//  carryout  out  1    carry out of MSB nibble (for sub: 1 = no borrow)
//  overflow  out  1    signed overflow of the W-bit operation
// BEHAVIOUR
//  Reset: state=IDLE, nibble index=0, carry reg=0, operand regs=0, sum=0,
//   carryout=0, overflow=0, done=0, busy=0, ready=1.
//  FSM: IDLE -start-> RUN ; RUN -(idx==WORDS-1)-> DONE ; DONE -start-> RUN ;
//   DONE -!start-> IDLE. Only IDLE/DONE accept start; start in RUN is ignored, not queued.
//  Accept (edge k): latch a, b^{W{sub}}, carry reg<=sub, idx<=0, enter RUN.
//  RUN, each edge: slice adds a_r[4i+:4] + b_r[4i+:4] + carry reg; write 4 result
//   bits into work reg nibble i; carry reg<=slice carry out; idx<=idx+1.
//  Last nibble (idx==WORDS-1): also capture carry into bit W-2->W-1 (c_msb)
//   from the slice; on that edge copy the work reg (with the new nibble) to sum,
//   carryout<=slice carry out, overflow<=c_msb ^ slice carry out; enter DONE.
//  Latency: start sampled at edge k -> done=1 during cycle after edge k+WORDS;
//   sustained throughput one operation per WORDS+1 cycles when start is held high.
//  Outputs sum/carryout/overflow change only at completion edge or reset; never
//   show partial results. done is high exactly one cycle per completed operation.
//  Arithmetic modulo 2^W; no saturation. WORDS=1 degenerates to 1 RUN cycle.
//  Reset asserted mid-RUN: operation abandoned, no done pulse, outputs cleared
//   to reset values immediately (asynchronous), FSM in IDLE after deassertion.
//  Operand inputs may change freely after acceptance; result uses latched values.
// TESTING (WORDS=4, W=16)
//  1. a=16'h7FFF b=16'h0001 sub=0, start 1 cycle -> busy 4 cycles, done 5th cycle
//     after accept edge; sum=16'h8000 carryout=0 overflow=1.
//  2. a=16'hFFFF b=16'h0001 sub=0 -> sum=16'h0000 carryout=1 overflow=0.
//  3. a=16'h0003 b=16'h0005 sub=1 -> sum=16'hFFFE carryout=0 overflow=0;
//     a=16'h8000 b=16'h0001 sub=1 -> sum=16'h7FFF carryout=1 overflow=1.
//  4. start pulsed during RUN with different operands -> ignored; first result
//     only, one done pulse; start held high through DONE -> back-to-back ops,
//     done pulses 5 cycles apart, second result correct.
//  5. reset asserted at 2nd RUN cycle -> sum=0 carryout=0 overflow=0 busy=0
//     ready=1 at once; no done pulse; next start after release completes correctly.
//  6. Randomised a,b,sub (>=1000 ops) vs reference model: sum, carryout, overflow.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Adds or subtracts two WORDS-nibble two's-complement operands by reusing a
//   single 4-bit ripple-carry slice, one nibble per clock, LSB nibble first.
//   The inter-nibble carry lives in a register. Results use 4-bit adder
//   semantics: carry out of the MSB nibble, and signed overflow taken from the
//   carries into and out of the top bit.
//
// Ports
//   clk_i       clock, rising edge
//   reset_i     asynchronous active-high reset; clears all state and outputs
//   start_i     operation request, sampled only while ready_o=1
//   sub_i       0: a+b, 1: a-b; sampled with start_i
//   a_i, b_i    W-bit operands; sampled with start_i
//   ready_o     high in IDLE and DONE (a start is accepted)
//   busy_o      high in RUN
//   done_o      one-cycle pulse; sum_o/carryout_o/overflow_o valid from here
//   sum_o       W-bit result, held until the next completion
//   carryout_o  carry out of the MSB nibble (subtract: 1 = no borrow)
//   overflow_o  signed overflow of the W-bit operation
module nibble_serial_adder_ctrl #(
    parameter int WORDS = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               sub_i,
    input  logic [4*WORDS-1:0] a_i,
    input  logic [4*WORDS-1:0] b_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [4*WORDS-1:0] sum_o,
    output logic               carryout_o,
    output logic               overflow_o
);

    localparam int W     = 4 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       a_nib, b_nib;
    logic [4:0]       slice;
    logic [3:0]       low3;
    logic             c_msb;
    logic             last;
    logic [W-1:0]     work_upd;

    // Shared 4-bit slice operating on the nibble selected by idx_q.
    always_comb begin
        a_nib    = '0;
        b_nib    = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
        // Carry into bit 3 of the slice; on the last nibble this is the carry
        // into the sign bit, needed for signed overflow.
        low3  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry_q};
        c_msb = low3[3];
        last  = (idx_q == IDX_W'(WORDS - 1));

        work_upd = work_q;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                work_upd[4*i +: 4] = slice[3:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    // Subtraction is a + ~b + 1: invert b once here and seed
                    // the carry chain with 1.
                    a_d     = a_i;
                    b_d     = b_i ^ {W{sub_i}};
                    carry_d = sub_i;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                work_d  = work_upd;
                carry_d = slice[4];
                idx_d   = idx_q + IDX_W'(1);
                if (last) begin
                    // Publish the whole word in one edge so outputs never
                    // show partial results.
                    idx_d   = '0;
                    sum_d   = work_upd;
                    cout_d  = slice[4];
                    ovf_d   = c_msb ^ slice[4];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // DONE lasts exactly one cycle (it always leaves on the next edge), so the
    // state decode itself is the done pulse.
    assign ready_o    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign sum_o      = sum_q;
    assign carryout_o = cout_q;
    assign overflow_o = ovf_q;

endmodule
